ps2_kbd_rx: RTL

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

---
 rtl/ps2_kbd_rx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver.
// Synchronizes ps2_clk/ps2_data into clk_sys, detects falling ps2_clk
// edges, deserializes 11-bit frames (start, 8 data LSB first, odd parity,
// stop), aborts stalled frames after TIMEOUT idle cycles, and decodes
// E0 (extended) / F0 (release) prefixes into key events.
//
// Ports:
//   clk_sys      system clock
//   reset        synchronous reset, active-high
//   ps2_clk      PS/2 clock (asynchronous, idle high)
//   ps2_data     PS/2 data (sampled on falling ps2_clk)
//   rx_byte      last correctly received byte
//   rx_strobe    one-cycle pulse, rx_byte updated
//   rx_error     one-cycle pulse on parity/stop/timeout failure
//   key_code     last non-prefix scancode
//   key_ext      key_code had an E0 prefix
//   key_release  key_code had an F0 prefix
//   key_strobe   one-cycle pulse, key_* outputs updated
module ps2_kbd_rx #(
  parameter int unsigned TIMEOUT = 32000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_error,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_strobe
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_meta, clk_sync, clk_prev;
  logic          data_meta, data_sync;
  logic          fall;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          ext_flag, ext_flag_n;
  logic          rel_flag, rel_flag_n;

  logic [7:0]    rx_byte_n, key_code_n;
  logic          rx_strobe_n, rx_error_n;
  logic          key_ext_n, key_release_n, key_strobe_n;

  // Synchronizers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      par         <= 1'b0;
      to_cnt      <= '0;
      ext_flag    <= 1'b0;
      rel_flag    <= 1'b0;
      rx_byte     <= '0;
      rx_strobe   <= 1'b0;
      rx_error    <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_strobe  <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      par         <= par_n;
      to_cnt      <= to_cnt_n;
      ext_flag    <= ext_flag_n;
      rel_flag    <= rel_flag_n;
      rx_byte     <= rx_byte_n;
      rx_strobe   <= rx_strobe_n;
      rx_error    <= rx_error_n;
      key_code    <= key_code_n;
      key_ext     <= key_ext_n;
      key_release <= key_release_n;
      key_strobe  <= key_strobe_n;
    end
  end

  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    shift_n       = shift;
    par_n         = par;
    to_cnt_n      = '0;
    ext_flag_n    = ext_flag;
    rel_flag_n    = rel_flag;
    rx_byte_n     = rx_byte;
    rx_strobe_n   = 1'b0;
    rx_error_n    = 1'b0;
    key_code_n    = key_code;
    key_ext_n     = key_ext;
    key_release_n = key_release;
    key_strobe_n  = 1'b0;

    if (state != IDLE && !fall)
      to_cnt_n = to_cnt + TW'(1);

    unique case (state)
      IDLE: begin
        if (fall && !data_sync) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_n   = {data_sync, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = data_sync;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (data_sync && ((^shift) ^ par)) begin
            rx_byte_n   = shift;
            rx_strobe_n = 1'b1;
            if (shift == 8'hE0) begin
              ext_flag_n = 1'b1;
            end else if (shift == 8'hF0) begin
              rel_flag_n = 1'b1;
            end else begin
              key_code_n    = shift;
              key_ext_n     = ext_flag;
              key_release_n = rel_flag;
              key_strobe_n  = 1'b1;
              ext_flag_n    = 1'b0;
              rel_flag_n    = 1'b0;
            end
          end else begin
            rx_error_n = 1'b1;
            ext_flag_n = 1'b0;
            rel_flag_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Expiry only applies when no edge arrived this cycle, so a
    // simultaneous edge is processed normally above.
    if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT - 1)) begin
      state_n    = IDLE;
      rx_error_n = 1'b1;
      ext_flag_n = 1'b0;
      rel_flag_n = 1'b0;
    end
  end

endmodule
